// File: rtl/queue_pkg.sv
// Shared widths, pointer arithmetic and error-bit indices for queue_peek_n.
// Error reporting is built only with QUEUE_PEEK_N_ERR_EN.
package queue_pkg;

  localparam int ERR_OVF = 1;
  localparam int ERR_UDF = 0;

  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int rw_of(input int peek);
    return $clog2(peek + 1);
  endfunction

  function automatic int pw_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned ptr_add(
    input int unsigned p,
    input int unsigned n,
    input int unsigned depth
  );
    return (p + n) % depth;
  endfunction

endpackage

// File: rtl/queue_peek_mux.sv
// Head window: rotates storage by rd_ptr into PEEK lanes.
// Lanes at or beyond the occupancy are forced to zero.
module queue_peek_mux
  import queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PEEK  = 2,
  parameter int CW    = cw_of(DEPTH),
  parameter int PW    = pw_of(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] i_mem,
  input  logic [PW-1:0]          i_rd_ptr,
  input  logic [CW-1:0]          i_count,
  output logic [PEEK-1:0]        o_vld,
  output logic [PEEK*WIDTH-1:0]  o_data
);

  for (genvar k = 0; k < PEEK; k++) begin : g_lane
    logic [PW-1:0]    idx;
    logic [WIDTH-1:0] word;

    assign idx  = PW'(ptr_add(32'(i_rd_ptr), k, DEPTH));
    assign word = i_mem[idx*WIDTH +: WIDTH];

    assign o_vld[k] = (i_count > CW'(k));
    assign o_data[k*WIDTH +: WIDTH] =
      o_vld[k] ? word : '0;
  end

endmodule

// File: rtl/queue_peek_n.sv
// Circular FIFO with PEEK-wide head window and multi-pop.
// Define QUEUE_PEEK_N_ERR_EN for sticky overflow/underflow flags.
module queue_peek_n
  import queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PEEK  = 2,
  parameter int AFULL = DEPTH - 1,
  parameter int CW    = cw_of(DEPTH),
  parameter int RW    = rw_of(PEEK)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
  output logic [CW-1:0]         o_count,
  output logic [PEEK-1:0]       o_vld,
  input  logic                  i_wr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [RW-1:0]         i_rd_n,
  output logic [PEEK*WIDTH-1:0] o_rd_data,
  output logic [1:0]            o_err
);

  localparam int PW = pw_of(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] rd_ext;
  logic [CW-1:0] pop;
  logic          wr;

  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign o_afull = (count >= CW'(AFULL));
  assign o_count = count;

  assign rd_ext = CW'(i_rd_n);
  assign pop    = (rd_ext > count) ? count : rd_ext;
  assign wr     = i_wr && !o_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= PW'(ptr_add(32'(wr_ptr), 1, DEPTH));
      end
      rd_ptr <= PW'(ptr_add(32'(rd_ptr), 32'(pop), DEPTH));
      count  <= count + CW'(wr) - pop;
    end
  end

  // Storage is left unreset; lanes past count are masked anyway.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  queue_peek_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PEEK  (PEEK),
    .CW    (CW),
    .PW    (PW)
  ) u_mux (
    .i_mem    (mem),
    .i_rd_ptr (rd_ptr),
    .i_count  (count),
    .o_vld    (o_vld),
    .o_data   (o_rd_data)
  );

`ifdef QUEUE_PEEK_N_ERR_EN
  logic [1:0] err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err <= '0;
    end else begin
      if (i_wr && o_full) begin
        err[ERR_OVF] <= 1'b1;
      end
      if (rd_ext > count) begin
        err[ERR_UDF] <= 1'b1;
      end
    end
  end

  assign o_err = err;
`else
  assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_queue_peek_n.sv
// Bench for queue_peek_n: directed plan plus random traffic
// checked every cycle against a queue-based reference.
module tb_queue_peek_n;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int PEEK  = 2;
  localparam int AFULL = 3;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RW    = $clog2(PEEK + 1);

  logic                  i_clk = 1'b0;
  logic                  i_rst = 1'b1;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_afull;
  logic [CW-1:0]         o_count;
  logic [PEEK-1:0]       o_vld;
  logic                  i_wr = 1'b0;
  logic [WIDTH-1:0]      i_wr_data = '0;
  logic [RW-1:0]         i_rd_n = '0;
  logic [PEEK*WIDTH-1:0] o_rd_data;
  logic [1:0]            o_err;

  queue_peek_n #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PEEK  (PEEK),
    .AFULL (AFULL)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_afull   (o_afull),
    .o_count   (o_count),
    .o_vld     (o_vld),
    .i_wr      (i_wr),
    .i_wr_data (i_wr_data),
    .i_rd_n    (i_rd_n),
    .o_rd_data (o_rd_data),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: plain queue of words plus sticky error bits.
  logic [WIDTH-1:0] q[$];
  logic [1:0]       m_err = 2'b00;
  bit               m_ok = 1'b0;

  always @(posedge i_clk) begin
    int n;
    bit wok;
    if (i_rst) begin
      q.delete();
      m_err = 2'b00;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      n   = (int'(i_rd_n) > q.size()) ? q.size() : int'(i_rd_n);
      wok = i_wr && (q.size() < DEPTH);
`ifdef QUEUE_PEEK_N_ERR_EN
      if (i_wr && q.size() == DEPTH) m_err[1] = 1'b1;
      if (int'(i_rd_n) > q.size()) m_err[0] = 1'b1;
`endif
      for (int i = 0; i < n; i++) void'(q.pop_front());
      if (wok) q.push_back(i_wr_data);
    end
  end

  always @(negedge i_clk) begin
    logic [PEEK*WIDTH-1:0] ed;
    logic [PEEK-1:0]       ev;
    if (m_ok) begin
      ed = '0;
      ev = '0;
      for (int k = 0; k < PEEK; k++) begin
        if (k < q.size()) begin
          ed[k*WIDTH +: WIDTH] = q[k];
          ev[k] = 1'b1;
        end
      end
      chk("count", 32'(o_count), 32'(q.size()));
      chk("full",  32'(o_full),  32'(q.size() == DEPTH));
      chk("empty", 32'(o_empty), 32'(q.size() == 0));
      chk("afull", 32'(o_afull), 32'(q.size() >= AFULL));
      chk("vld",   32'(o_vld),   32'(ev));
      chk("data",  32'(o_rd_data), 32'(ed));
      chk("err",   32'(o_err),   32'(m_err));
    end
  end

  task automatic cyc(input bit wr, input logic [7:0] d,
                     input int rn, input bit rst = 1'b0);
    i_wr      = wr;
    i_wr_data = d;
    i_rd_n    = RW'(rn);
    i_rst     = rst;
    @(posedge i_clk);
    #1;
    i_wr   = 1'b0;
    i_rd_n = '0;
    i_rst  = 1'b0;
  endtask

  initial begin
    cyc(1'b1, 8'hEE, 2, 1'b1);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_vld",   32'(o_vld),   0);
    chk("rst_err",   32'(o_err),   0);

    cyc(1'b1, 8'h11, 0);
    chk("p1_count1", 32'(o_count), 1);
    cyc(1'b1, 8'h22, 0);
    chk("p1_vld", 32'(o_vld), 2'b11);
    chk("p1_data", 32'(o_rd_data), 16'h2211);
    cyc(1'b1, 8'h33, 0);
    chk("p1_count3", 32'(o_count), 3);
    chk("p1_afull", 32'(o_afull), 1);

    cyc(1'b1, 8'h44, 0);
    chk("p2_full", 32'(o_full), 1);
    cyc(1'b1, 8'h55, 1);
    chk("p2_count", 32'(o_count), 3);
    chk("p2_data", 32'(o_rd_data), 16'h3322);

    cyc(1'b0, 8'h00, 1);
    chk("p3_data_a", 32'(o_rd_data), 16'h4433);
    cyc(1'b1, 8'h66, 1);
    chk("p3_wrap", 32'(o_rd_data), 16'h6644);
    cyc(1'b1, 8'h77, 2);
    chk("p3_data_b", 32'(o_rd_data), 16'h0077);

    cyc(1'b1, 8'h99, 1);
    chk("p4_one", 32'(o_rd_data), 16'h0099);
    cyc(1'b0, 8'h00, 2);
    chk("p4_count", 32'(o_count), 0);
    chk("p4_empty", 32'(o_empty), 1);
    chk("p4_vld", 32'(o_vld), 0);
    chk("p4_data", 32'(o_rd_data), 0);
`ifdef QUEUE_PEEK_N_ERR_EN
    chk("p4_err", 32'(o_err), 2'b11);
`else
    chk("p4_err", 32'(o_err), 2'b00);
`endif

    cyc(1'b1, 8'hCD, 0);
    cyc(1'b1, 8'hAB, 1);
    chk("p5_count", 32'(o_count), 1);
    chk("p5_data", 32'(o_rd_data), 16'h00AB);
    chk("p5_vld", 32'(o_vld), 2'b01);

    cyc(1'b1, 8'h01, 0);
    cyc(1'b1, 8'h02, 0);
    chk("p6_pre", 32'(o_count), 3);
    cyc(1'b1, 8'h5A, 0, 1'b1);
    chk("p6_count", 32'(o_count), 0);
    chk("p6_empty", 32'(o_empty), 1);
    chk("p6_err", 32'(o_err), 0);
    cyc(1'b1, 8'h12, 0);
    chk("p6_data", 32'(o_rd_data), 16'h0012);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 60),
          8'($urandom),
          int'($urandom_range(0, PEEK)),
          ($urandom_range(0, 199) == 0));
    end

    @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
